// File: rtl/sprite_pkg.sv
// Shared widths, FSM encoding and sprite bitmap for the scanline generator.
// Bitmap bit 0 is the leftmost pixel of the sprite.
package sprite_pkg;

  localparam int DEF_ROW_W   = 240;
  localparam int DEF_SPR_W   = 12;
  localparam int DEF_SPR_H   = 10;
  localparam int DEF_POS_W   = 9;
  localparam int DEF_NUM_SPR = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  function automatic logic [DEF_SPR_W-1:0] bitmap_row(
    input logic [3:0] r
  );
    logic [DEF_SPR_W-1:0] v;
    case (r)
      4'd0:    v = 12'h060;
      4'd1:    v = 12'h1F8;
      4'd2:    v = 12'h3FC;
      4'd3:    v = 12'h3FC;
      4'd4:    v = 12'h7FE;
      4'd5:    v = 12'h7FE;
      4'd6:    v = 12'h3FC;
      4'd7:    v = 12'h3FC;
      4'd8:    v = 12'h1F8;
      4'd9:    v = 12'h060;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sprite_row_gen_if.sv
// Row request / rendered row bundle between game logic and row writer.
// Packed sprite fields: slot i lives at [i*POS_W +: POS_W].
interface sprite_row_gen_if #(
  parameter int ROW_W   = 240,
  parameter int NUM_SPR = 2,
  parameter int POS_W   = 9
);
  logic                     req_valid;
  logic                     req_ready;
  logic [POS_W-1:0]         req_row;
  logic [NUM_SPR-1:0]       spr_en;
  logic [NUM_SPR*POS_W-1:0] spr_x;
  logic [NUM_SPR*POS_W-1:0] spr_y;
  logic                     row_valid;
  logic [ROW_W-1:0]         row_data;
  logic                     collision;

  modport master (
    output req_valid, req_row, spr_en, spr_x, spr_y,
    input  req_ready, row_valid, row_data, collision
  );

  modport slave (
    input  req_valid, req_row, spr_en, spr_x, spr_y,
    output req_ready, row_valid, row_data, collision
  );
endinterface

// File: rtl/sprite_bitmap_rom.sv
// Combinational sprite bitmap lookup; rows past the sprite height read 0.
// Row index is the wrapped distance from the sprite's top row.
module sprite_bitmap_rom
  import sprite_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic [POS_W-1:0] rel,
  output logic [SPR_W-1:0] bm
);

  always_comb begin
    bm = '0;
    if (rel < POS_W'(SPR_H)) bm = SPR_W'(bitmap_row(rel[3:0]));
  end

endmodule

// File: rtl/sprite_row_gen.sv
// Sequential multi-sprite scanline engine: one sprite slot per cycle,
// OR-accumulated row mask with pixel overlap detection.
module sprite_row_gen
  import sprite_pkg::*;
#(
  parameter int ROW_W   = DEF_ROW_W,
  parameter int SPR_W   = DEF_SPR_W,
  parameter int SPR_H   = DEF_SPR_H,
  parameter int NUM_SPR = DEF_NUM_SPR,
  parameter int POS_W   = DEF_POS_W
) (
  input logic clk,
  input logic rst_n,
  sprite_row_gen_if.slave bus
);

  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SPR - 1);

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [POS_W-1:0]         row_q, row_d;
  logic [NUM_SPR-1:0]       en_q, en_d;
  logic [NUM_SPR*POS_W-1:0] x_q, x_d;
  logic [NUM_SPR*POS_W-1:0] y_q, y_d;
  logic [ROW_W-1:0]         acc_q, acc_d;
  logic                     coll_q, coll_d;
  logic                     rv_q, rv_d;
  logic                     rdy_q, rdy_d;

  logic [POS_W-1:0] x_i, y_i, rel;
  logic [SPR_W-1:0] bm;
  logic [ROW_W-1:0] bm_ext, shifted;
  logic             hit;

  assign x_i = x_q[int'(idx_q)*POS_W +: POS_W];
  assign y_i = y_q[int'(idx_q)*POS_W +: POS_W];
  assign rel = row_q - y_i;
  assign hit = en_q[idx_q] && (rel < POS_W'(SPR_H));

  sprite_bitmap_rom #(
    .POS_W(POS_W),
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_rom (
    .rel(rel),
    .bm (bm)
  );

  // Shifts of ROW_W or more naturally fall off the top: full clip.
  assign bm_ext  = ROW_W'(bm);
  assign shifted = bm_ext << x_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    en_d    = en_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    coll_d  = coll_q;
    rv_d    = 1'b0;
    rdy_d   = rdy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          row_d   = bus.req_row;
          en_d    = bus.spr_en;
          x_d     = bus.spr_x;
          y_d     = bus.spr_y;
          acc_d   = '0;
          coll_d  = 1'b0;
          idx_d   = '0;
          rdy_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          acc_d  = acc_q | shifted;
          coll_d = coll_q | (|(acc_q & shifted));
        end
        if (idx_q == LAST) state_d = ST_DONE;
        else idx_d = idx_q + 1'b1;
      end
      ST_DONE: begin
        rv_d    = 1'b1;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      en_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      coll_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      en_q    <= en_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      coll_q  <= coll_d;
      rv_q    <= rv_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.row_valid = rv_q;
  assign bus.row_data  = acc_q;
  assign bus.collision = coll_q;

endmodule

// File: tb/tb_sprite_row_gen.sv
// Directed and random row requests checked against a per-pixel
// coverage-count model of the sprites.
module tb_sprite_row_gen;

  localparam int ROW_W = 240;
  localparam int POS_W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  int bmp [10] = '{'h060, 'h1F8, 'h3FC, 'h3FC, 'h7FE,
                   'h7FE, 'h3FC, 'h3FC, 'h1F8, 'h060};

  always #5 clk = ~clk;

  sprite_row_gen_if #(.ROW_W(ROW_W), .NUM_SPR(2), .POS_W(POS_W)) bus ();

  sprite_row_gen u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(string tag, logic [ROW_W-1:0] obs,
                     logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count how many enabled sprites paint each column.
  task automatic model(input int row, input logic [1:0] en,
                       input int xs[2], input int ys[2],
                       output logic [ROW_W-1:0] data,
                       output logic coll);
    data = '0;
    coll = 1'b0;
    for (int k = 0; k < ROW_W; k++) begin
      int cnt = 0;
      for (int s = 0; s < 2; s++) begin
        int rel = (row - ys[s] + 512) % 512;
        int c = k - xs[s];
        if (en[s] && rel < 10 && c >= 0 && c < 12)
          if (((bmp[rel] >> c) & 1) == 1) cnt++;
      end
      if (cnt > 0) data[k] = 1'b1;
      if (cnt > 1) coll = 1'b1;
    end
  endtask

  task automatic drive(int row, logic [1:0] en, int x0, int y0,
                       int x1, int y1);
    bus.req_row = POS_W'(row);
    bus.spr_en  = en;
    bus.spr_x   = {POS_W'(x1), POS_W'(x0)};
    bus.spr_y   = {POS_W'(y1), POS_W'(y0)};
  endtask

  task automatic run_req(string tag, int row, logic [1:0] en,
                         int x0, int y0, int x1, int y1);
    logic [ROW_W-1:0] ed;
    logic ce;
    int n;
    model(row, en, '{x0, x1}, '{y0, y1}, ed, ce);
    @(negedge clk);
    chk({tag, "_rdy"}, ROW_W'(bus.req_ready), 1);
    drive(row, en, x0, y0, x1, y1);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.row_valid && n < 10);
    chk({tag, "_lat"}, ROW_W'(n), 3);
    chk({tag, "_data"}, bus.row_data, ed);
    chk({tag, "_coll"}, ROW_W'(bus.collision), ROW_W'(ce));
    @(posedge clk);
    #1;
    chk({tag, "_rvlo"}, ROW_W'(bus.row_valid), 0);
    chk({tag, "_hold"}, bus.row_data, ed);
  endtask

  initial begin
    logic [ROW_W-1:0] ed;
    logic ce;
    int pulses;
    bus.req_valid = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0);
    #12;
    chk("rst_rdy", ROW_W'(bus.req_ready), 1);
    chk("rst_rv", ROW_W'(bus.row_valid), 0);
    chk("rst_data", bus.row_data, 0);
    chk("rst_coll", ROW_W'(bus.collision), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("single", 21, 2'b01, 0, 20, 0, 0);
    chk("single_const", bus.row_data, ROW_W'(12'h1F8));
    run_req("clip", 34, 2'b01, 235, 30, 0, 0);
    chk("clip_const", bus.row_data, {4'hF, 236'h0});
    run_req("ywrap9", 2, 2'b01, 40, 505, 0, 0);
    chk("ywrap9_const", bus.row_data, ROW_W'(12'h060) << 40);
    run_req("ywrap11", 4, 2'b01, 40, 505, 0, 0);
    chk("ywrap11_const", bus.row_data, 0);
    run_req("coll", 54, 2'b11, 100, 50, 100, 50);
    chk("coll_const", bus.row_data, ROW_W'(12'h7FE) << 100);
    chk("coll_flag", ROW_W'(bus.collision), 1);
    run_req("nocoll", 54, 2'b11, 100, 50, 120, 50);
    chk("nocoll_flag", ROW_W'(bus.collision), 0);
    run_req("xfar", 54, 2'b11, 300, 50, 239, 50);
    run_req("dis", 54, 2'b00, 100, 50, 120, 50);

    // Request held and inputs scrambled during SCAN.
    model(21, 2'b01, '{0, 0}, '{20, 0}, ed, ce);
    @(negedge clk);
    drive(21, 2'b01, 0, 20, 0, 0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(54, 2'b11, 100, 50, 100, 50);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.row_valid) pulses++;
    end
    bus.req_valid = 1'b0;
    chk("hs_data", bus.row_data, ed);
    chk("hs_coll", ROW_W'(bus.collision), ROW_W'(ce));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.row_valid) pulses++;
    end
    chk("hs_pulses", ROW_W'(pulses), 1);

    // Reset in the middle of a scan aborts the row.
    @(negedge clk);
    drive(54, 2'b11, 100, 50, 100, 50);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", ROW_W'(bus.req_ready), 1);
    chk("abort_data", bus.row_data, 0);
    chk("abort_coll", ROW_W'(bus.collision), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.row_valid) pulses++;
    end
    chk("abort_norv", ROW_W'(pulses), 0);

    for (int t = 0; t < 25; t++) begin
      int y0, y1, x0, x1, row;
      y0 = int'($urandom_range(0, 511));
      y1 = (y0 + int'($urandom_range(0, 8))) % 512;
      x0 = int'($urandom_range(0, 260));
      x1 = (t % 2 == 0) ? x0 + int'($urandom_range(0, 14))
                        : int'($urandom_range(0, 260));
      row = (y0 + int'($urandom_range(0, 12))) % 512;
      run_req("rand", row, 2'($urandom_range(0, 3)), x0, y0,
              x1 % 512, y1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_row_gen.md
# sprite_row_gen

Parametrised multi-sprite scanline generator for the LCD path. For each requested display row it walks every enabled sprite, fetches that sprite's bitmap row from a built-in bitmap ROM, shifts it to the sprite's horizontal position, ORs it into a ROW_W-bit row mask, and flags pixel overlap between sprites. The block sits between the game-logic position registers and the LCD row writer. It replaces the single fixed-ball, vertical-only combinational lookup with a handshaked, sequential engine that handles horizontal placement, clipping and collision.

## Interface
- ROW_W, 240, row mask width (display pixels per row)
- SPR_W, 12, sprite bitmap width in pixels
- SPR_H, 10, sprite bitmap height in rows
- NUM_SPR, 2, number of sprite slots
- POS_W, 9, width of row index and sprite X/Y coordinates
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  row request strobe
- req_ready  out  1  high when the block can accept a request (IDLE)
- req_row  in  POS_W  display row to render
- spr_en  in  NUM_SPR  per-sprite enable
- spr_x  in  NUM_SPR*POS_W  packed X positions; slot i at [i*POS_W +: POS_W]
- spr_y  in  NUM_SPR*POS_W  packed Y positions, same packing
- row_valid  out  1  one-cycle pulse, row_data and collision valid
- row_data  out  ROW_W  rendered row mask; bit k = display column k
- collision  out  1  two or more sprites set the same bit in this row

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: req_ready=1. On req_valid, latch req_row, spr_en, spr_x and spr_y. Clear the accumulator, collision and sprite index. Go to SCAN.
- SCAN: one sprite per cycle, index i = 0..NUM_SPR-1.
  - rel = (row - y_i) mod 2^POS_W.
  - Hit when spr_en[i] and rel < SPR_H.
  - On a hit: bm = rom[rel], zero-extended to ROW_W, then shifted left by x_i. Bits at or above ROW_W are discarded.
  - acc <= acc | bm. collision <= collision | (|(acc & bm)).
  - After i = NUM_SPR-1, go to DONE.
- DONE: row_valid=1 for one cycle, row_data=acc, then return to IDLE.
- row_data and collision hold their value until the next request is accepted.
- Requests while not in IDLE are ignored; req_ready=0, so there is no queueing. Input changes during SCAN have no effect because the inputs were latched.
- Bitmap ROM contents, rows 0..9 with bit 0 = leftmost pixel: 060, 1F8, 3FC, 3FC, 7FE, 7FE, 3FC, 3FC, 1F8, 060 (hex). rel ≥ SPR_H returns 0.
- Y wrap: modular subtraction lets a sprite near row 2^POS_W-1 appear at the top rows.
- X ≥ ROW_W: the sprite is fully clipped and contributes zero.

## Timing
- Reset values: state=IDLE, req_ready=1, row_valid=0, row_data=0, collision=0, all latches and index=0.
- Latency: request accepted at edge N; row_valid high in the cycle after edge N+NUM_SPR+1. Default is 3 edges.
- Throughput: one row per NUM_SPR+2 cycles. The next accept is possible in the cycle after DONE.
- Reset asserted mid-SCAN: immediate return to IDLE and outputs cleared. No row_valid is produced for the aborted request.
- All arithmetic is unsigned. rel is POS_W bits. The shift amount is POS_W bits, and any shift ≥ ROW_W yields 0.

## Structure
- Package sprite_pkg holds the default widths (ROW_W, SPR_W, SPR_H, POS_W), the FSM state encoding, and the bitmap constant rows.
- Sub-module sprite_bitmap_rom: combinational, input rel[POS_W-1:0], output bm[SPR_W-1:0]. The FSM, accumulator and shifter live in the top.

## Test plan
- Reset then idle: rst_n low mid-run -> req_ready=1, row_data=0, collision=0, no row_valid.
- Single sprite: spr_en=01, y0=20, x0=0, req_row=21 -> after 3 edges row_data=0x1F8, collision=0.
- Horizontal shift and clip: x0=235, req_row=y0+4 -> row_data bits 236..239 set, all others 0.
- Y wrap: y0=505, req_row=2 -> rel=9, row_data=0x060 at x0. req_row=4 -> rel=11, row_data=0.
- Collision: both sprites enabled at x=100, y=50, req_row=54 -> row_data=0x7FE<<100, collision=1. Sprite 1 moved to x=120 -> collision=0, both masks ORed.
- Handshake: second req_valid held during SCAN -> ignored. A request asserted in IDLE after DONE is accepted, giving exactly one row_valid per accepted request.
